mmio_sig_responder: RTL and testbench

- Synthesizable responder for the tiny-SoC MMIO signalling window at 0x6000_0000. It decodes core-issued stop, trap, integer-register-dump and FP-register-dump accesses.
- Dump values are queued in a ready/valid FIFO with register tags. Stop and trap are tracked through a drain-then-halt state machine.
- It sits on the SoC mmio_* port, in place of a passive tie-off, and is used by FPGA and emulation builds that have no simulator monitor.

---
 rtl/mmio_sig_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_mmio_sig_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_sig_responder.sv
// MMIO signalling-window responder: decodes stop/trap/register-dump accesses,
// queues dump values in a tagged FIFO and runs a drain-then-halt state machine.
module mmio_sig_responder #(
   parameter logic [31:0] ADDR_BASE    = 32'h6000_0000,
   parameter int unsigned DRAIN_CYCLES = 50,
   parameter int unsigned DUMP_DEPTH   = 8,
   parameter bit          STOP_ON_TRAP = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mmio_req_i,
   input  logic        mmio_we_i,
   input  logic [31:0] mmio_addr_i,
   input  logic [7:0]  mmio_strb_i,
   input  logic [63:0] mmio_wdata_i,
   output logic [63:0] mmio_rdata_o,
   output logic        stop_o,
   output logic        trap_o,
   output logic        halted_o,
   output logic [7:0]  trap_cnt_o,
   output logic        dump_valid_o,
   input  logic        dump_ready_i,
   output logic        dump_is_fp_o,
   output logic [4:0]  dump_idx_o,
   output logic [63:0] dump_data_o,
   output logic        dump_ovf_o,
   output logic [1:0]  dbg_state_o
);

   localparam int unsigned PTR_W  = $clog2(DUMP_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned CNT_W  = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   localparam logic [31:0] OFF_STOP   = 32'h00;
   localparam logic [31:0] OFF_TRAP   = 32'h08;
   localparam logic [31:0] OFF_REG    = 32'h10;
   localparam logic [31:0] OFF_FREG   = 32'h18;
   localparam logic [31:0] OFF_STATUS = 32'h20;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   typedef struct packed {
      logic        is_fp;
      logic [4:0]  idx;
      logic [63:0] data;
   } dump_t;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                stop_q, stop_d;
   logic                trap_q, trap_d;
   logic                halted_q, halted_d;
   logic [7:0]          trap_cnt_q, trap_cnt_d;
   logic [4:0]          int_idx_q, int_idx_d;
   logic [4:0]          fp_idx_q, fp_idx_d;
   logic                ovf_q, ovf_d;
   logic [63:0]         rdata_q, rdata_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   dump_t               mem_q [DUMP_DEPTH];
   dump_t               mem_d [DUMP_DEPTH];

   logic [31:0] offset;
   logic        hit_stop, hit_trap, hit_reg, hit_freg;
   logic        push_req, push, pop, full;
   logic [63:0] wmask;
   logic [7:0]  trap_cnt_inc;
   logic [63:0] status_w;
   dump_t       push_entry;
   dump_t       head;

   assign offset   = mmio_addr_i - ADDR_BASE;
   assign hit_stop = mmio_req_i && mmio_we_i && (offset == OFF_STOP);
   assign hit_trap = mmio_req_i && (offset == OFF_TRAP);
   assign hit_reg  = mmio_req_i && mmio_we_i && (offset == OFF_REG) && (state_q == ST_RUN);
   assign hit_freg = mmio_req_i && mmio_we_i && (offset == OFF_FREG) && (state_q == ST_RUN);

   assign trap_cnt_inc = (trap_cnt_q == 8'hFF) ? 8'hFF : trap_cnt_q + 8'd1;

   assign status_w = {38'd0, trap_cnt_q, halted_q, trap_q, stop_q, ovf_q,
                      fp_idx_q, int_idx_q, 4'(fcnt_q)};

   always_comb begin
      wmask = '0;
      for (int i = 0; i < 8; i++) begin
         wmask[i*8 +: 8] = {8{mmio_strb_i[i]}};
      end
   end

   // Dump FIFO handshake: the head is offered while dump_valid_o is high and is
   // consumed on any cycle where dump_valid_o && dump_ready_i; no push bypass.
   assign full     = (fcnt_q == FCNT_W'(DUMP_DEPTH));
   assign pop      = (fcnt_q != '0) && dump_ready_i;
   assign push_req = hit_reg || hit_freg;
   assign push     = push_req && (!full || pop);

   always_comb begin
      push_entry.is_fp = hit_freg;
      push_entry.idx   = hit_freg ? fp_idx_q : int_idx_q;
      push_entry.data  = mmio_wdata_i & wmask;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fcnt_d   = fcnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
         2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      stop_d     = stop_q;
      trap_d     = trap_q;
      halted_d   = halted_q;
      trap_cnt_d = trap_cnt_q;
      int_idx_d  = int_idx_q;
      fp_idx_d   = fp_idx_q;
      ovf_d      = ovf_q;

      case (state_q)
         ST_RUN: begin
            if (hit_stop || (hit_trap && STOP_ON_TRAP)) begin
               if (DRAIN_CYCLES == 0) begin
                  state_d  = ST_HALTED;
                  halted_d = 1'b1;
               end else begin
                  state_d = ST_DRAIN;
                  cnt_d   = CNT_W'(DRAIN_CYCLES);
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
            // cnt hits zero on this edge, so halted_o lands DRAIN_CYCLES+1 after the trigger
            if (cnt_q <= CNT_W'(1)) begin
               state_d  = ST_HALTED;
               halted_d = 1'b1;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      if (hit_stop) begin
         stop_d = 1'b1;
      end
      if (hit_trap) begin
         trap_d     = 1'b1;
         trap_cnt_d = trap_cnt_inc;
      end
      if (hit_reg) begin
         int_idx_d = int_idx_q + 5'd1;
      end
      if (hit_freg) begin
         fp_idx_d = fp_idx_q + 5'd1;
      end
      if (push_req && !push) begin
         ovf_d = 1'b1;
      end
   end

   // A TRAP read reports the count including the access being read.
   always_comb begin
      rdata_d = rdata_q;
      if (mmio_req_i && !mmio_we_i) begin
         case (offset)
            OFF_TRAP:   rdata_d = {56'd0, trap_cnt_inc};
            OFF_STATUS: rdata_d = status_w;
            default:    rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         stop_q     <= 1'b0;
         trap_q     <= 1'b0;
         halted_q   <= 1'b0;
         trap_cnt_q <= '0;
         int_idx_q  <= 5'd1;
         fp_idx_q   <= 5'd0;
         ovf_q      <= 1'b0;
         rdata_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stop_q     <= stop_d;
         trap_q     <= trap_d;
         halted_q   <= halted_d;
         trap_cnt_q <= trap_cnt_d;
         int_idx_q  <= int_idx_d;
         fp_idx_q   <= fp_idx_d;
         ovf_q      <= ovf_d;
         rdata_q    <= rdata_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fcnt_q     <= fcnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign head = mem_q[rd_ptr_q];

   assign mmio_rdata_o = rdata_q;
   assign stop_o       = stop_q;
   assign trap_o       = trap_q;
   assign halted_o     = halted_q;
   assign trap_cnt_o   = trap_cnt_q;
   assign dump_ovf_o   = ovf_q;
   assign dump_valid_o = (fcnt_q != '0);
   assign dump_is_fp_o = dump_valid_o ? head.is_fp : 1'b0;
   assign dump_idx_o   = dump_valid_o ? head.idx : 5'd0;
   assign dump_data_o  = dump_valid_o ? head.data : 64'd0;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mmio_sig_responder.sv
// Directed bench for mmio_sig_responder: one instance stops on trap, a second
// only counts traps; expected values are hand-computed constants.
module tb_mmio_sig_responder;

   localparam logic [31:0] BASE = 32'h6000_0000;
   localparam int W  = 72;
   localparam int EW = 70;

   logic        clk;
   logic        rst;
   logic        req, req2, we;
   logic [31:0] addr;
   logic [7:0]  strb;
   logic [63:0] wdata;
   logic        ready, ready2;

   logic [63:0] rdata, rdata2;
   logic        stop, trap, halted, dvalid, dis_fp, ovf;
   logic        stop2, trap2, halted2, dvalid2, dis_fp2, ovf2;
   logic [7:0]  trap_cnt, trap_cnt2;
   logic [4:0]  didx, didx2;
   logic [63:0] ddata, ddata2;
   logic [1:0]  st, st2;

   int          cyc;
   int          t0;
   int          n_checks;
   int          n_errors;
   logic [EW-1:0] exp_q[$];

   mmio_sig_responder #(.STOP_ON_TRAP(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .mmio_req_i(req), .mmio_we_i(we),
      .mmio_addr_i(addr), .mmio_strb_i(strb), .mmio_wdata_i(wdata),
      .mmio_rdata_o(rdata), .stop_o(stop), .trap_o(trap), .halted_o(halted),
      .trap_cnt_o(trap_cnt), .dump_valid_o(dvalid), .dump_ready_i(ready),
      .dump_is_fp_o(dis_fp), .dump_idx_o(didx), .dump_data_o(ddata),
      .dump_ovf_o(ovf), .dbg_state_o(st)
   );

   mmio_sig_responder #(.STOP_ON_TRAP(1'b0)) dut_nt (
      .clk_i(clk), .rst_i(rst), .mmio_req_i(req2), .mmio_we_i(we),
      .mmio_addr_i(addr), .mmio_strb_i(strb), .mmio_wdata_i(wdata),
      .mmio_rdata_o(rdata2), .stop_o(stop2), .trap_o(trap2), .halted_o(halted2),
      .trap_cnt_o(trap_cnt2), .dump_valid_o(dvalid2), .dump_ready_i(ready2),
      .dump_is_fp_o(dis_fp2), .dump_idx_o(didx2), .dump_data_o(ddata2),
      .dump_ovf_o(ovf2), .dbg_state_o(st2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // driver tasks: inputs change on the falling edge, DUT samples on the rising edge
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic bus_write(input bit sel2, input logic [31:0] off, input logic [63:0] data,
                            input logic [7:0] be, input bit rdy);
      @(negedge clk);
      if (sel2) req2 = 1'b1; else req = 1'b1;
      we    = 1'b1;
      addr  = BASE + off;
      wdata = data;
      strb  = be;
      ready = rdy;
      @(negedge clk);
      req   = 1'b0;
      req2  = 1'b0;
      we    = 1'b0;
      ready = 1'b0;
   endtask

   task automatic bus_read(input bit sel2, input logic [31:0] off);
      @(negedge clk);
      if (sel2) req2 = 1'b1; else req = 1'b1;
      we   = 1'b0;
      addr = BASE + off;
      @(negedge clk);
      req  = 1'b0;
      req2 = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic fp, input logic [4:0] idx,
                             input logic [63:0] data);
      check(tag, {dvalid, dis_fp, didx, ddata}, {1'b1, fp, idx, data});
   endtask

   // scoreboard: drain the FIFO, comparing each head against the expected queue
   task automatic sb_drain();
      while (exp_q.size() != 0) begin
         check("sb_head", {dvalid, dis_fp, didx, ddata}, {1'b1, exp_q[0]});
         void'(exp_q.pop_front());
         pop_one();
      end
      check("sb_empty", dvalid, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; addr = '0;
      strb = '0; wdata = '0; ready = 1'b0; ready2 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_flags", {stop, trap, halted, dvalid, ovf, st}, '0);
      check("rst_trap_cnt", trap_cnt, 8'd0);
      check("rst_rdata", rdata, 64'd0);
      bus_read(0, 32'h20);
      check("rst_status", rdata, 64'h10);

      // integer dumps, tags 1 then 2
      bus_write(0, 32'h10, 64'h1111, 8'hFF, 1'b0);
      check_head("reg_head0", 1'b0, 5'd1, 64'h1111);
      bus_write(0, 32'h10, 64'h2222, 8'hFF, 1'b0);
      check_head("reg_head0_kept", 1'b0, 5'd1, 64'h1111);
      pop_one();
      check_head("reg_head1", 1'b0, 5'd2, 64'h2222);
      pop_one();
      check("reg_empty", dvalid, 1'b0);
      bus_read(0, 32'h20);
      check("status_idx3", rdata, 64'h30);

      // fp dump with partial byte enables
      bus_write(0, 32'h18, 64'hDEAD_BEEF_0123_4567, 8'h0F, 1'b0);
      check_head("freg_strb", 1'b1, 5'd0, 64'h0000_0000_0123_4567);
      pop_one();
      bus_read(0, 32'h20);
      check("status_fp1", rdata, 64'h230);

      // trap counting only (second instance)
      for (int i = 0; i < 3; i++) bus_write(1, 32'h08, 64'd0, 8'hFF, 1'b0);
      check("nt_cnt3", trap_cnt2, 8'd3);
      check("nt_flags", {stop2, trap2, halted2, st2}, 5'b01000);
      repeat (60) @(negedge clk);
      check("nt_no_halt", {halted2, st2}, 3'b000);
      for (int i = 0; i < 251; i++) bus_write(1, 32'h08, 64'd0, 8'hFF, 1'b0);
      check("nt_cnt254", trap_cnt2, 8'd254);
      bus_read(1, 32'h08);
      check("nt_read255", rdata2, 64'd255);
      check("nt_cnt255", trap_cnt2, 8'd255);
      bus_read(1, 32'h08);
      check("nt_read_sat", rdata2, 64'd255);
      bus_write(1, 32'h30, 64'hFFFF, 8'hFF, 1'b0);
      check("nt_rdata_hold", rdata2, 64'd255);
      bus_read(1, 32'h28);
      check("nt_unmapped_rd", rdata2, 64'd0);
      bus_read(1, 32'h00);
      check("nt_wo_rd", rdata2, 64'd0);
      check("nt_no_stop", {stop2, st2}, 3'b000);

      // fill to full, then pop+push together, then overflow
      for (int i = 0; i < 8; i++) begin
         bus_write(0, 32'h10, 64'h100 + 64'(i), 8'hFF, 1'b0);
         exp_q.push_back({1'b0, 5'(3 + i), 64'h100 + 64'(i)});
      end
      check("full_no_ovf", ovf, 1'b0);
      bus_read(0, 32'h20);
      check("status_full", rdata, 64'h2B8);
      check_head("full_head", 1'b0, 5'd3, 64'h100);
      void'(exp_q.pop_front());
      bus_write(0, 32'h10, 64'h1AA, 8'hFF, 1'b1);
      exp_q.push_back({1'b0, 5'd11, 64'h1AA});
      check("full_pop_push_ovf", ovf, 1'b0);
      bus_read(0, 32'h20);
      check("status_pop_push", rdata, 64'h2C8);
      bus_write(0, 32'h10, 64'h1BB, 8'hFF, 1'b0);
      check("full_drop_ovf", ovf, 1'b1);
      bus_read(0, 32'h20);
      check("status_drop", rdata, 64'h42D8);
      sb_drain();

      // integer index wrap 31 -> 0
      for (int i = 0; i < 19; i++) bus_write(0, 32'h10, 64'h300 + 64'(i), 8'hFF, 1'b1);
      check_head("wrap_idx31", 1'b0, 5'd31, 64'h312);
      bus_read(0, 32'h20);
      check("status_wrap0", rdata, 64'h4201);
      bus_write(0, 32'h10, 64'h3FF, 8'hFF, 1'b1);
      check_head("wrap_idx0", 1'b0, 5'd0, 64'h3FF);
      bus_read(0, 32'h20);
      check("status_wrap1", rdata, 64'h4211);
      pop_one();
      check("wrap_empty", dvalid, 1'b0);

      // STOP: drain timing and dump blocking
      bus_write(0, 32'h00, 64'd1, 8'hFF, 1'b0);
      t0 = cyc - 1;
      check("stop_t1", {stop, trap, halted, st}, 5'b10001);
      while (cyc < t0 + 4) @(negedge clk);
      bus_write(0, 32'h10, 64'h5555, 8'hFF, 1'b0);
      check("drain_dump_dropped", dvalid, 1'b0);
      bus_read(0, 32'h20);
      check("status_drain", rdata, 64'hC210);
      while (cyc < t0 + 50) @(negedge clk);
      check("stop_t50_not_halted", halted, 1'b0);
      @(negedge clk);
      check("stop_t51_halted", {halted, st}, 3'b110);
      bus_read(0, 32'h20);
      check("status_halted", rdata, 64'h2C210);
      bus_write(0, 32'h08, 64'd0, 8'hFF, 1'b0);
      check("halted_trap", {trap, trap_cnt, st}, {1'b1, 8'd1, 2'd2});

      // TRAP read starts drain; a second trap does not restart the count
      do_reset();
      check("rst2_flags", {stop, trap, halted, dvalid, ovf, st, trap_cnt}, '0);
      bus_read(0, 32'h08);
      t0 = cyc - 1;
      check("trap_rd_data", rdata, 64'd1);
      check("trap_t1", {stop, trap, halted, st}, 5'b01001);
      while (cyc < t0 + 9) @(negedge clk);
      bus_write(0, 32'h08, 64'd0, 8'hFF, 1'b0);
      check("trap_cnt2", trap_cnt, 8'd2);
      while (cyc < t0 + 50) @(negedge clk);
      check("trap_t50_not_halted", halted, 1'b0);
      @(negedge clk);
      check("trap_t51_halted", {halted, st}, 3'b110);

      // reset in the middle of a drain with a queued dump
      do_reset();
      bus_write(0, 32'h10, 64'h77, 8'hFF, 1'b0);
      bus_write(0, 32'h00, 64'd1, 8'hFF, 1'b0);
      t0 = cyc - 1;
      while (cyc < t0 + 30) @(negedge clk);
      do_reset();
      check("midrst_flags", {stop, trap, halted, dvalid, ovf, st, trap_cnt}, '0);
      check("midrst_rdata", rdata, 64'd0);
      bus_read(0, 32'h20);
      check("midrst_status", rdata, 64'h10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
